// File: rtl/reg_file_dp.sv
// reg_file_dp: configuration register file with one masked write port,
// two independent read ports (A, B), per-entry reset image, optional second
// read stage and a lock bit that write-protects the exported entries.
module reg_file_dp #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int NUM_EXPORT = 4,
  parameter logic [DEPTH*DATA_WIDTH-1:0] RST_VALS =
    (DEPTH*DATA_WIDTH)'(16'h0821) << (2*DATA_WIDTH),
  parameter int LOCK_ADDR  = DEPTH-1,
  parameter int RD_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             RST,
  input  logic                             WrEn,
  input  logic [ADDR_WIDTH-1:0]            WrAddr,
  input  logic [DATA_WIDTH-1:0]            WrData,
  input  logic [DATA_WIDTH-1:0]            WrMask,
  output logic                             WrErr,
  input  logic                             RdEnA,
  input  logic [ADDR_WIDTH-1:0]            RdAddrA,
  output logic [DATA_WIDTH-1:0]            RdDataA,
  output logic                             RdValidA,
  output logic                             RdErrA,
  input  logic                             RdEnB,
  input  logic [ADDR_WIDTH-1:0]            RdAddrB,
  output logic [DATA_WIDTH-1:0]            RdDataB,
  output logic                             RdValidB,
  output logic                             RdErrB,
  output logic [NUM_EXPORT*DATA_WIDTH-1:0] REGS
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] NEXP_L  = (ADDR_WIDTH+1)'(NUM_EXPORT);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  // Decoded mux over the real entries, so addresses past DEPTH never index
  // outside the array.
  function automatic logic [DATA_WIDTH-1:0] entry_at(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < DEPTH; i++)
      if (a == ADDR_WIDTH'(i)) v = mem[i];
    return v;
  endfunction

  logic                  lock_on;
  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] wr_merged;

  logic                  rd_en      [2];
  logic [ADDR_WIDTH-1:0] rd_addr    [2];
  logic [DATA_WIDTH-1:0] rd_data_p0 [2];
  logic                  rd_oor_p0  [2];
  logic [DATA_WIDTH-1:0] data_p1    [2];
  logic                  vld_p1     [2];
  logic                  err_p1     [2];
  logic [DATA_WIDTH-1:0] rd_data    [2];
  logic                  rd_vld     [2];
  logic                  rd_err     [2];

  assign rd_en[0]   = RdEnA;
  assign rd_en[1]   = RdEnB;
  assign rd_addr[0] = RdAddrA;
  assign rd_addr[1] = RdAddrB;

  // Write acceptance uses the pre-edge lock bit, so a write that sets the
  // lock is itself accepted; the lock register is never an exported entry.
  always_comb begin
    lock_on   = mem[LOCK_ADDR][0];
    wr_ok     = WrEn && in_range(WrAddr) && !(lock_on && ({1'b0, WrAddr} < NEXP_L));
    wr_merged = (entry_at(WrAddr) & ~WrMask) | (WrData & WrMask);
  end

  // Read stage 0: out-of-range detection plus write-first bypass of an
  // accepted same-address write.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_oor_p0[p] = !in_range(rd_addr[p]);
      if (rd_oor_p0[p])
        rd_data_p0[p] = '0;
      else if (wr_ok && (WrAddr == rd_addr[p]))
        rd_data_p0[p] = wr_merged;
      else
        rd_data_p0[p] = entry_at(rd_addr[p]);
    end
  end

  // Register array: reset image load, masked merge on accepted writes.
  always_ff @(posedge clk) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= RST_VALS[i*DATA_WIDTH +: DATA_WIDTH];
    end else if (wr_ok) begin
      for (int i = 0; i < DEPTH; i++)
        if (WrAddr == ADDR_WIDTH'(i)) mem[i] <= wr_merged;
    end
  end

  // Write error pulse for the cycle after a rejected request.
  always_ff @(posedge clk) begin
    if (RST) WrErr <= 1'b0;
    else     WrErr <= WrEn && !wr_ok;
  end

  // Stage 0 -> 1: data holds its last value when no request is sampled.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (RST) begin
        vld_p1[p]  <= 1'b0;
        err_p1[p]  <= 1'b0;
        data_p1[p] <= '0;
      end else begin
        vld_p1[p] <= rd_en[p];
        err_p1[p] <= rd_en[p] && rd_oor_p0[p];
        if (rd_en[p]) data_p1[p] <= rd_data_p0[p];
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] data_p2 [2];
      logic                  vld_p2  [2];
      logic                  err_p2  [2];

      // Stage 1 -> 2: plain delay, no bypass from writes landing later.
      always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
          if (RST) begin
            vld_p2[p]  <= 1'b0;
            err_p2[p]  <= 1'b0;
            data_p2[p] <= '0;
          end else begin
            vld_p2[p] <= vld_p1[p];
            err_p2[p] <= err_p1[p];
            if (vld_p1[p]) data_p2[p] <= data_p1[p];
          end
        end
      end
      assign rd_data = data_p2;
      assign rd_vld  = vld_p2;
      assign rd_err  = err_p2;
    end else begin : g_lat1
      assign rd_data = data_p1;
      assign rd_vld  = vld_p1;
      assign rd_err  = err_p1;
    end
  endgenerate

  assign RdDataA  = rd_data[0];
  assign RdValidA = rd_vld[0];
  assign RdErrA   = rd_err[0];
  assign RdDataB  = rd_data[1];
  assign RdValidB = rd_vld[1];
  assign RdErrB   = rd_err[1];

  for (genvar i = 0; i < NUM_EXPORT; i++) begin : g_regs
    assign REGS[i*DATA_WIDTH +: DATA_WIDTH] = mem[i];
  end

endmodule

// File: doc/reg_file_dp.md
Name: reg_file_dp

Overview:
Next-generation configuration register file. It has one masked write port and two independent read ports (A, B), per-entry reset values, an optional second read pipeline stage, and a lock that write-protects the exported configuration registers. It sits between the system controller (writes, port A reads) and a secondary reader such as a debug or status path (port B). The first NUM_EXPORT entries drive the datapath as a flat bus.

Parameters:
DATA_WIDTH, 8, width of each entry
ADDR_WIDTH, 4, address width
DEPTH, 16, number of entries (DEPTH <= 2**ADDR_WIDTH)
NUM_EXPORT, 4, entries 0..NUM_EXPORT-1 exported on REGS (1 <= NUM_EXPORT < DEPTH)
RST_VALS, entry2=8'h21 / entry3=8'h08 / others 0, flattened DEPTH*DATA_WIDTH reset image; entry i at bits [i*DATA_WIDTH +: DATA_WIDTH]
LOCK_ADDR, DEPTH-1, index of the lock register (must be >= NUM_EXPORT)
RD_LATENCY, 1, read latency in cycles, 1 or 2

Ports:
clk  in  1  clock; all logic on rising edge
RST  in  1  reset, synchronous, active-high
WrEn  in  1  write request
WrAddr  in  ADDR_WIDTH  write address
WrData  in  DATA_WIDTH  write data
WrMask  in  DATA_WIDTH  per-bit write enable (1 = update bit)
WrErr  out  1  one-cycle pulse: previous write rejected
RdEnA  in  1  port A read request
RdAddrA  in  ADDR_WIDTH  port A address
RdDataA  out  DATA_WIDTH  port A read data
RdValidA  out  1  port A data valid pulse
RdErrA  out  1  port A out-of-range flag, aligned with RdValidA
RdEnB, RdAddrB, RdDataB, RdValidB, RdErrB  as port A
REGS  out  NUM_EXPORT*DATA_WIDTH  entry i at bits [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset (RST=1 at an edge): all entries load RST_VALS. RdData*, RdValid*, RdErr*, WrErr and all read pipeline stages go to 0. Requests sampled in a reset cycle are dropped. A read in flight is cancelled, with no valid pulse.
- Write: if WrEn=1 and the write is accepted, entry[WrAddr] <= (entry & ~WrMask) | (WrData & WrMask) at the edge. WrMask=0 is an accepted no-op.
- Write rejection: the write is rejected if WrAddr >= DEPTH, or if lock bit entry[LOCK_ADDR][0]=1 and WrAddr < NUM_EXPORT. On rejection, no array change and WrErr=1 in the next cycle only.
- The lock register is always writable. Clearing bit0 unlocks writes from the next cycle on.
- A write that sets the lock does not block itself. The lock is evaluated on the pre-edge value.
- Read ports are fully independent. Both ports may read the same or different addresses, concurrently with a write, in any cycle (no mutual exclusion).
- Read latency: with RdEn sampled at edge N, RdValid=1 and RdData is valid after edge N+RD_LATENCY. RdValid pulses once per request. Back-to-back requests give back-to-back valids.
- Write-first bypass: a read sampled in the same cycle as an accepted write to the same address returns the merged new value. A rejected write is never bypassed.
- Out-of-range read (addr >= DEPTH): RdData=0 and RdErr=1, aligned with RdValid.
- When RdValid=0, RdData holds its last value and RdErr=0.
- RD_LATENCY=2: one extra registered stage on data/valid/err. There is no bypass across stages, so a write landing after the read was sampled is not reflected.
- REGS reflects array contents combinationally from the registers, so it updates the cycle after an accepted write.

Test Plan:
- Reset, then read addresses 2, 3 and 0 on port A -> 8'h21, 8'h08, 8'h00. REGS = {8'h08, 8'h21, 8'h00, 8'h00}.
- Write addr 5, data 8'hFF, mask 8'h0F over existing 8'hA0 -> port B read returns 8'hAF one cycle later (RD_LATENCY=1) with RdValidB one pulse.
- Same cycle: write addr 7 = 8'h3C and A/B read addr 7 -> both ports return 8'h3C (bypass). A read of addr 6 on B concurrently returns the old value.
- Write entry[15] = 8'h01 (lock), then write addr 1 = 8'h55 -> WrErr pulses, REGS[1] unchanged. Write entry[15] = 0, then addr 1 = 8'h55 -> accepted, no WrErr.
- Parameter set DEPTH=12: read addr 13 -> RdData=0, RdErr=1, RdValid=1. Write addr 12 -> WrErr=1, no change.
- RD_LATENCY=2: read issued, RST asserted next cycle -> no RdValid. Entry 2 back to 8'h21. Later reads valid exactly 2 cycles after request.
